relu_maxpool_list: RTL and testbench

RELU_MAXPOOL_LIST -- requirements
Module: relu_maxpool_list

---
 rtl/relu_maxpool_list.sv | 102 ++++++++++
 tb/tb_relu_maxpool_list.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/relu_maxpool_list.sv
// relu_maxpool_list: per-channel ReLU followed by 2x2 max-pooling over a raster stream,
// using a half-row line buffer for the even-row pair maxima.
module relu_maxpool_list #(
    parameter int DWIDTH   = 16,
    parameter int PE_NUM   = 8,
    parameter int MAX_FMAP = 28
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [4:0]               fmap_size,
    input  logic                     in_valid,
    input  logic [PE_NUM*DWIDTH-1:0] din,
    output logic                     out_valid,
    output logic [PE_NUM*DWIDTH-1:0] dout,
    output logic                     frame_done
);
    localparam int W = PE_NUM * DWIDTH;
    localparam int LB = MAX_FMAP / 2;
    localparam int AW = $clog2(LB);
    localparam logic [4:0] MAXS = 5'(MAX_FMAP);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, next_state;
    logic [4:0] size_q, size, col, row;
    logic [W-1:0] hold, relu_v, pair_v, pool_v;
    logic [W-1:0] linebuf [LB];
    logic [AW-1:0] lb_idx;
    logic legal, accept, col_end, last;

    function automatic logic signed [DWIDTH-1:0] smax(input logic signed [DWIDTH-1:0] a,
                                                      input logic signed [DWIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign legal   = fmap_size >= 5'd2 && !fmap_size[0] && fmap_size <= MAXS;
    assign size    = (state == ACTIVE) ? size_q : fmap_size;
    assign accept  = in_valid && !flush && (state == ACTIVE || legal);
    assign col_end = col == size - 5'd1;
    assign last    = col_end && row == size - 5'd1;
    assign lb_idx  = col[AW:1];

    always_comb begin
        relu_v = '0;
        pair_v = '0;
        pool_v = '0;
        for (int i = 0; i < PE_NUM; i++) begin
            relu_v[i*DWIDTH +: DWIDTH] = din[i*DWIDTH+DWIDTH-1] ? '0 : din[i*DWIDTH +: DWIDTH];
            pair_v[i*DWIDTH +: DWIDTH] = smax(hold[i*DWIDTH +: DWIDTH], relu_v[i*DWIDTH +: DWIDTH]);
            pool_v[i*DWIDTH +: DWIDTH] = smax(linebuf[lb_idx][i*DWIDTH +: DWIDTH], pair_v[i*DWIDTH +: DWIDTH]);
        end
    end

    always_comb begin
        next_state = state;
        if (flush)
            next_state = IDLE;
        else if (accept)
            next_state = last ? IDLE : ACTIVE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_q     <= '0;
            col        <= '0;
            row        <= '0;
            hold       <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            dout       <= '0;
        end else begin
            out_valid  <= accept && row[0] && col[0];
            frame_done <= accept && last;
            if (flush) begin
                col  <= '0;
                row  <= '0;
                hold <= '0;
            end else if (accept) begin
                if (state == IDLE)
                    size_q <= fmap_size;
                col <= col_end ? '0 : col + 5'd1;
                row <= last ? '0 : (col_end ? row + 5'd1 : row);
                if (!col[0])
                    hold <= relu_v;
                if (row[0] && col[0])
                    dout <= pool_v;
            end
        end
    end

    // Even-row pair maxima wait here for the matching odd row; never read before written.
    always_ff @(posedge clk)
        if (accept && !row[0] && col[0])
            linebuf[lb_idx] <= pair_v;
endmodule

// File: tb/tb_relu_maxpool_list.sv
// tb_relu_maxpool_list: random and directed frames checked against a frame-array
// reference that pools each completed 2x2 block with plain arithmetic.
module tb_relu_maxpool_list;
    localparam int DW = 16;
    localparam int PE = 4;
    localparam int MF = 28;
    localparam int W  = DW * PE;

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0;
    logic [4:0] fmap_size = '0;
    logic [W-1:0] din = '0;
    logic out_valid, frame_done;
    logic [W-1:0] dout;

    relu_maxpool_list #(.DWIDTH(DW), .PE_NUM(PE), .MAX_FMAP(MF)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .fmap_size(fmap_size),
        .in_valid(in_valid), .din(din), .out_valid(out_valid), .dout(dout),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic [W-1:0] d;
        logic         done;
    } exp_t;

    exp_t q[$];
    int cyc = 0, n_vec = 0, n_err = 0;
    logic [W-1:0] last_d = '0;
    logic [W-1:0] frame [MF][MF];
    bit in_frame = 1'b0;
    int size = 0, k = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        return {$urandom, $urandom};
    endfunction

    function automatic bit legal(input logic [4:0] sz);
        return sz >= 2 && sz % 2 == 0 && int'(sz) <= MF;
    endfunction

    // Max over the 2x2 block ending at (r,c); starting from 0 applies the ReLU.
    function automatic logic [W-1:0] pool(input int r, input int c);
        logic [W-1:0] res, p;
        int m, x;
        res = '0;
        for (int ch = 0; ch < PE; ch++) begin
            m = 0;
            for (int dr = 0; dr < 2; dr++)
                for (int dc = 0; dc < 2; dc++) begin
                    p = frame[r-dr][c-dc];
                    x = $signed(p[ch*DW +: DW]);
                    if (x > m) m = x;
                end
            res[ch*DW +: DW] = m[DW-1:0];
        end
        return res;
    endfunction

    always @(negedge clk) begin
        bit e;
        e = (q.size() > 0) && (q[0].due == cyc);
        chk("out_valid", W'(out_valid), W'(e));
        if (e) begin
            chk("dout", dout, q[0].d);
            chk("frame_done", W'(frame_done), W'(q[0].done));
            last_d = q[0].d;
            void'(q.pop_front());
        end else begin
            chk("dout_hold", dout, last_d);
            chk("frame_done_idle", W'(frame_done), '0);
        end
    end

    task automatic drive(input bit v, input bit f, input logic [4:0] sz, input logic [W-1:0] d);
        int r, c;
        @(posedge clk);
        #1;
        in_valid  = v;
        flush     = f;
        fmap_size = sz;
        din       = d;
        if (f) begin
            in_frame = 1'b0;
            k = 0;
        end else if (v && (in_frame || legal(sz))) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                size = int'(sz);
                k = 0;
            end
            r = k / size;
            c = k % size;
            frame[r][c] = d;
            if (r % 2 == 1 && c % 2 == 1)
                q.push_back('{due: cyc + 1, d: pool(r, c), done: (k == size * size - 1)});
            k++;
            if (k == size * size) begin
                in_frame = 1'b0;
                k = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        q.delete();
        last_d = '0;
        in_frame = 1'b0;
        k = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_frame(input int sz, input int gap, input bit chg);
        for (int i = 0; i < sz * sz; i++) begin
            while ($urandom_range(99) < gap) drive(1'b0, 1'b0, 5'(sz), rnd());
            drive(1'b1, 1'b0, (chg && i > 0) ? 5'($urandom) : 5'(sz), rnd());
        end
    endtask

    initial begin
        logic [W-1:0] d;
        int vals [4];
        vals = '{-3, 7, 2, -9};
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        // 1..16 in channel 0: pooled 6, 8, 14, 16
        for (int i = 0; i < 16; i++) begin
            d = rnd();
            d[DW-1:0] = 16'(i + 1);
            drive(1'b1, 1'b0, 5'd4, d);
        end
        for (int i = 0; i < 4; i++) begin
            d = rnd();
            d[DW-1:0] = 16'hFFFB;
            d[2*DW-1:DW] = 16'(vals[i]);
            drive(1'b1, 1'b0, 5'd2, d);
        end
        drive(1'b1, 1'b0, 5'd3, rnd());
        drive(1'b1, 1'b0, 5'd0, rnd());
        drive(1'b1, 1'b0, 5'd1, rnd());
        drive(1'b1, 1'b0, 5'd30, rnd());
        drive(1'b0, 1'b0, 5'd4, rnd());
        run_frame(4, 50, 1'b0);
        run_frame(4, 0, 1'b1);
        run_frame(6, 0, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 5'd4, rnd());
        drive(1'b1, 1'b1, 5'd4, rnd());
        run_frame(4, 0, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 5'd4, rnd());
        do_reset();
        run_frame(4, 20, 1'b0);
        for (int f = 0; f < 8; f++) begin
            run_frame(2 * $urandom_range(1, 14), $urandom_range(0, 50), 1'($urandom));
            if ($urandom_range(3) == 0) begin
                for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 5'd6, rnd());
                drive(1'b1, 1'b1, 5'd6, rnd());
            end
        end
        run_frame(28, 10, 1'b1);
        repeat (4) drive(1'b0, 1'b0, 5'd0, rnd());
        chk("queue_empty", W'(q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
